// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage.
// Load-type codes, stage states and register constants.
package wb_pkg;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LH  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LW  = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    ALU     = 2'd1,
    WAIT_LD = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data lane extraction and extension.
// Purely combinational; also flags misaligned accesses.
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      ld_type,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  assign byte_l = rdata[8*off +: 8];
  assign half_l = off[1] ? rdata[31:16] : rdata[15:0];

  // Select lane, extend, and check alignment
  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    unique case (1'b1)
      (ld_type == LD_LB): begin
        data = {{(XLEN-8){byte_l[7]}}, byte_l};
      end
      (ld_type == LD_LBU): begin
        data = {{(XLEN-8){1'b0}}, byte_l};
      end
      (ld_type == LD_LH): begin
        data       = {{(XLEN-16){half_l[15]}}, half_l};
        misaligned = off[0];
      end
      (ld_type == LD_LHU): begin
        data       = {{(XLEN-16){1'b0}}, half_l};
        misaligned = off[0];
      end
      default: begin
        data       = rdata;
        misaligned = (off != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: holds one retiring instruction,
// waits for load data, drives the register-file write.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RCNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_flush,
  input  logic              mem_reg_we,
  input  logic [4:0]        mem_rd,
  input  logic [XLEN-1:0]   mem_alu_res,
  input  logic              mem_is_load,
  input  logic [2:0]        mem_ld_type,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              ld_pending,
  output logic [4:0]        ld_pending_rd,
  output logic              exc_misalign,
  output logic [RCNT_W-1:0] retire_cnt
);

  wb_state_t       state_q;
  wb_state_t       state_d;
  logic            reg_we_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_q;
  logic            is_load_q;
  logic [2:0]      ld_type_q;
  logic [1:0]      off_q;

  logic            completing;
  logic            capture;
  logic [XLEN-1:0] ld_data;
  logic            ld_mis;
  logic            mis;

  load_align #(.XLEN(XLEN)) u_align (
    .ld_type    (ld_type_q),
    .off        (off_q),
    .rdata      (dmem_rdata),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  assign completing = (state_q == ALU)
                    | ((state_q == WAIT_LD) & dmem_rvalid);
  assign mem_ready  = !((state_q == WAIT_LD) & !dmem_rvalid);
  assign capture    = mem_valid & mem_ready & !mem_flush;
  assign mis        = is_load_q & ld_mis;

  assign ld_pending    = (state_q == WAIT_LD);
  assign ld_pending_rd = ld_pending ? rd_q : REG_ZERO;

  // Register-file write port, zeroed when idle
  always_comb begin
    rf_we    = completing & reg_we_q & (rd_q != REG_ZERO) & !mis;
    rf_waddr = rd_q;
    rf_wdata = '0;
    if (rf_we)
      rf_wdata = is_load_q ? ld_data : alu_q;
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    if (capture)
      state_d = mem_is_load ? WAIT_LD : ALU;
    else if (completing)
      state_d = EMPTY;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  // Captured instruction fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_we_q  <= 1'b0;
      rd_q      <= REG_ZERO;
      alu_q     <= '0;
      is_load_q <= 1'b0;
      ld_type_q <= 3'd0;
      off_q     <= 2'd0;
    end else if (capture) begin
      reg_we_q  <= mem_reg_we;
      rd_q      <= mem_rd;
      alu_q     <= mem_alu_res;
      is_load_q <= mem_is_load;
      ld_type_q <= mem_ld_type;
      off_q     <= mem_alu_res[1:0];
    end
  end

  // Retire counter and misalign exception pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt   <= '0;
      exc_misalign <= 1'b0;
    end else begin
      exc_misalign <= completing & mis;
      if (completing)
        retire_cnt <= retire_cnt + RCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for the write-back stage.
// Hand-computed vectors checked with immediate assertions.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_flush;
  logic        mem_reg_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_alu_res;
  logic        mem_is_load;
  logic [2:0]  mem_ld_type;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ld_pending;
  logic [4:0]  ld_pending_rd;
  logic        exc_misalign;
  logic [31:0] retire_cnt;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32), .RCNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_flush     (mem_flush),
    .mem_reg_we    (mem_reg_we),
    .mem_rd        (mem_rd),
    .mem_alu_res   (mem_alu_res),
    .mem_is_load   (mem_is_load),
    .mem_ld_type   (mem_ld_type),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .ld_pending    (ld_pending),
    .ld_pending_rd (ld_pending_rd),
    .exc_misalign  (exc_misalign),
    .retire_cnt    (retire_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic ld, input logic [2:0] ty,
                         input logic [4:0] rd,
                         input logic [31:0] a);
    mem_valid   = 1'b1;
    mem_reg_we  = 1'b1;
    mem_is_load = ld;
    mem_ld_type = ty;
    mem_rd      = rd;
    mem_alu_res = a;
  endtask

  // Capture a load, wait one cycle, then present its data.
  task automatic do_load(input logic [2:0] ty, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] d);
    present(1'b1, ty, rd, a);
    tick();
    mem_valid = 1'b0;
    tick();
    dmem_rvalid = 1'b1;
    dmem_rdata  = d;
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_valid   = 1'b0;
    mem_flush   = 1'b0;
    mem_reg_we  = 1'b0;
    mem_rd      = 5'd0;
    mem_alu_res = 32'd0;
    mem_is_load = 1'b0;
    mem_ld_type = 3'd0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'd0;
    #12;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_pending", {31'd0, ld_pending}, 32'd0);
    chk("rst_ready", {31'd0, mem_ready}, 32'd1);
    chk("rst_cnt", retire_cnt, 32'd0);
    chk("rst_exc", {31'd0, exc_misalign}, 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU write
    present(1'b0, 3'd0, 5'd5, 32'h1234_5678);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("alu_we", {31'd0, rf_we}, 32'd1);
    chk("alu_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("alu_wdata", rf_wdata, 32'h1234_5678);
    tick();
    chk("alu_cnt", retire_cnt, 32'd1);
    chk("alu_idle_we", {31'd0, rf_we}, 32'd0);

    // LB off=2 with 3 wait cycles
    present(1'b1, 3'd0, 5'd3, 32'h0000_0102);
    tick();
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lb_pending", {31'd0, ld_pending}, 32'd1);
      chk("lb_ready", {31'd0, mem_ready}, 32'd0);
      chk("lb_prd", {27'd0, ld_pending_rd}, 32'd3);
      tick();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0080_0000;
    #1;
    chk("lb_we", {31'd0, rf_we}, 32'd1);
    chk("lb_waddr", {27'd0, rf_waddr}, 32'd3);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    chk("lb_ready_done", {31'd0, mem_ready}, 32'd1);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    chk("lb_cnt", retire_cnt, 32'd2);
    chk("lb_not_pending", {31'd0, ld_pending}, 32'd0);

    // LBU off=2
    do_load(3'd1, 5'd8, 32'h0000_0202, 32'h0080_0000);
    chk("lbu_wdata", rf_wdata, 32'h0000_0080);
    tick();
    dmem_rvalid = 1'b0;

    // LH off=2
    do_load(3'd2, 5'd9, 32'h0000_0302, 32'h8001_0000);
    chk("lh_wdata", rf_wdata, 32'hFFFF_8001);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    chk("lh_cnt", retire_cnt, 32'd4);

    // ALU write to x0
    present(1'b0, 3'd0, 5'd0, 32'hDEAD_BEEF);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("x0_we", {31'd0, rf_we}, 32'd0);
    chk("x0_wdata", rf_wdata, 32'd0);
    tick();
    chk("x0_cnt", retire_cnt, 32'd5);

    // Misaligned LW off=1
    do_load(3'd4, 5'd10, 32'h0000_0401, 32'hAAAA_AAAA);
    chk("mis_we", {31'd0, rf_we}, 32'd0);
    chk("mis_exc_early", {31'd0, exc_misalign}, 32'd0);
    tick();
    dmem_rvalid = 1'b0;
    #1;
    chk("mis_exc", {31'd0, exc_misalign}, 32'd1);
    chk("mis_cnt", retire_cnt, 32'd6);
    tick();
    chk("mis_exc_clr", {31'd0, exc_misalign}, 32'd0);

    // Load completes while ALU rd=7 is captured
    do_load(3'd4, 5'd4, 32'h0000_0500, 32'h1122_3344);
    present(1'b0, 3'd0, 5'd7, 32'h0000_0077);
    #1;
    chk("b2b_ready", {31'd0, mem_ready}, 32'd1);
    chk("b2b_ld_waddr", {27'd0, rf_waddr}, 32'd4);
    chk("b2b_ld_wdata", rf_wdata, 32'h1122_3344);
    tick();
    mem_valid   = 1'b0;
    dmem_rvalid = 1'b0;
    #1;
    chk("b2b_alu_we", {31'd0, rf_we}, 32'd1);
    chk("b2b_alu_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("b2b_alu_wdata", rf_wdata, 32'h0000_0077);
    chk("b2b_cnt1", retire_cnt, 32'd7);
    tick();
    chk("b2b_cnt2", retire_cnt, 32'd8);

    // Flushed capture
    present(1'b0, 3'd0, 5'd9, 32'h0000_0099);
    mem_flush = 1'b1;
    tick();
    mem_valid = 1'b0;
    mem_flush = 1'b0;
    #1;
    chk("flush_we", {31'd0, rf_we}, 32'd0);
    tick();
    chk("flush_cnt", retire_cnt, 32'd8);

    // Reset while waiting on a load
    present(1'b1, 3'd4, 5'd6, 32'h0000_0600);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("rl_pending", {31'd0, ld_pending}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rl_pending_clr", {31'd0, ld_pending}, 32'd0);
    tick();
    rst_n       = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_5555;
    #1;
    chk("rl_we", {31'd0, rf_we}, 32'd0);
    chk("rl_ready", {31'd0, mem_ready}, 32'd1);
    tick();
    dmem_rvalid = 1'b0;
    chk("rl_cnt", retire_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
